// File: rtl/risc_toy_pkg.sv
// RISC_TOY shared definitions for the memory stage.
// Control bundle, data-port encodings and defaults.
package risc_toy_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 30;
  localparam int RW_DEF = 5;

  localparam logic DRW_WR = 1'b1;
  localparam logic DRW_RD = 1'b0;

  typedef struct packed {
    logic valid;
    logic rd;
    logic wr;
    logic regwr;
  } mem_ctrl_t;

  // rd+wr together behaves as a plain store that never writes back
  function automatic mem_ctrl_t ctrl_pack(
    input logic v,
    input logic rd,
    input logic wr,
    input logic regwr
  );
    mem_ctrl_t c;
    c.valid = v;
    c.wr    = v & wr;
    c.rd    = v & rd & ~wr;
    c.regwr = v & regwr & ~wr;
    return c;
  endfunction

endpackage

// File: rtl/risc_toy_pipe_reg.sv
// RISC_TOY pipeline register with hold and clear.
// Hold wins over clear; reset is asynchronous.
module risc_toy_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (!hold)
      q <= clear ? '0 : d;
  end

endmodule

// File: rtl/risc_toy_mem_stage.sv
// RISC_TOY memory-access stage: EX/MEM, data port,
// MEM/WB write-back and forwarding taps.
module risc_toy_mem_stage
  import risc_toy_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          STALL,
  input  logic          FLUSH,
  input  logic          EX_VALID,
  input  logic [DW-1:0] EX_RESULT,
  input  logic [DW-1:0] EX_STDATA,
  input  logic          EX_MEMRD,
  input  logic          EX_MEMWR,
  input  logic          EX_REGWR,
  input  logic [RW-1:0] EX_WA,
  output logic          DREQ,
  output logic          DRW,
  output logic [AW-1:0] DADDR,
  output logic [DW-1:0] DWDATA,
  input  logic [DW-1:0] DRDATA,
  output logic          FWD_M_VALID,
  output logic [RW-1:0] FWD_M_WA,
  output logic [DW-1:0] FWD_M_DATA,
  output logic          LD_PENDING,
  output logic [RW-1:0] LD_WA,
  output logic          WB_WEN,
  output logic [RW-1:0] WB_WA,
  output logic [DW-1:0] WB_DI
);

  typedef struct packed {
    mem_ctrl_t     c;
    logic [RW-1:0] wa;
    logic [DW-1:0] result;
    logic [DW-1:0] stdata;
  } ex_mem_t;

  typedef struct packed {
    logic          wen;
    logic [RW-1:0] wa;
    logic [DW-1:0] di;
  } mem_wb_t;

  ex_mem_t m_d, m_q;
  mem_wb_t w_d, w_q;

  always_comb begin
    m_d.c      = ctrl_pack(EX_VALID, EX_MEMRD,
                           EX_MEMWR, EX_REGWR);
    m_d.wa     = EX_WA;
    m_d.result = EX_RESULT;
    m_d.stdata = EX_STDATA;
  end

  risc_toy_pipe_reg #(.W($bits(ex_mem_t))) u_ex_mem (
    .clk   (CLK),
    .rst   (RST),
    .hold  (STALL),
    .clear (FLUSH),
    .d     (m_d),
    .q     (m_q)
  );

  // A held access waits for the first unstalled cycle
  always_comb begin
    DREQ   = m_q.c.valid & (m_q.c.rd | m_q.c.wr) & ~STALL;
    DRW    = m_q.c.wr ? DRW_WR : DRW_RD;
    DADDR  = DREQ ? m_q.result[AW+1:2] : '0;
    DWDATA = DREQ ? m_q.stdata : '0;
  end

  always_comb begin
    FWD_M_VALID = m_q.c.valid & m_q.c.regwr & ~m_q.c.rd;
    FWD_M_WA    = m_q.wa;
    FWD_M_DATA  = m_q.result;
    LD_PENDING  = m_q.c.valid & m_q.c.rd;
    LD_WA       = m_q.wa;
  end

  always_comb begin
    w_d.wen = m_q.c.valid & m_q.c.regwr & ~m_q.c.wr;
    w_d.wa  = m_q.wa;
    w_d.di  = m_q.c.rd ? DRDATA : m_q.result;
  end

  risc_toy_pipe_reg #(.W($bits(mem_wb_t))) u_mem_wb (
    .clk   (CLK),
    .rst   (RST),
    .hold  (1'b0),
    .clear (STALL),
    .d     (w_d),
    .q     (w_q)
  );

  assign WB_WEN = w_q.wen;
  assign WB_WA  = w_q.wa;
  assign WB_DI  = w_q.di;

endmodule

// File: tb/tb_risc_toy_mem_stage.sv
// Bench for risc_toy_mem_stage: directed cases plus
// random traffic against an instruction-level model.
module tb_risc_toy_mem_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        STALL, FLUSH;
  logic        EX_VALID, EX_MEMRD, EX_MEMWR, EX_REGWR;
  logic [31:0] EX_RESULT, EX_STDATA;
  logic [4:0]  EX_WA;
  logic        DREQ, DRW;
  logic [29:0] DADDR;
  logic [31:0] DWDATA, DRDATA;
  logic        FWD_M_VALID, LD_PENDING, WB_WEN;
  logic [4:0]  FWD_M_WA, LD_WA, WB_WA;
  logic [31:0] FWD_M_DATA, WB_DI;

  always #5 CLK = ~CLK;

  risc_toy_mem_stage dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
    .EX_VALID(EX_VALID), .EX_RESULT(EX_RESULT),
    .EX_STDATA(EX_STDATA), .EX_MEMRD(EX_MEMRD),
    .EX_MEMWR(EX_MEMWR), .EX_REGWR(EX_REGWR),
    .EX_WA(EX_WA), .DREQ(DREQ), .DRW(DRW),
    .DADDR(DADDR), .DWDATA(DWDATA), .DRDATA(DRDATA),
    .FWD_M_VALID(FWD_M_VALID), .FWD_M_WA(FWD_M_WA),
    .FWD_M_DATA(FWD_M_DATA), .LD_PENDING(LD_PENDING),
    .LD_WA(LD_WA), .WB_WEN(WB_WEN), .WB_WA(WB_WA),
    .WB_DI(WB_DI)
  );

  typedef struct {
    bit        v, rd, wr, regwr;
    bit [4:0]  wa;
    bit [31:0] res, st;
  } ins_t;

  typedef struct {
    bit [4:0]  wa;
    bit [31:0] di;
  } wb_t;

  ins_t        slot;
  wb_t         q[$];
  bit [31:0]   mmem[16];
  logic [31:0] dmem[16];
  int          total = 0;
  int          bad = 0;
  bit          run = 0;

  // Small data memory answering the DUT's port
  always @(posedge CLK)
    if (!RST && DREQ && DRW) dmem[DADDR[3:0]] = DWDATA;

  always_comb
    DRDATA = (DREQ && !DRW) ? dmem[DADDR[3:0]]
                            : 32'hA5A5_5A5A;

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  function automatic ins_t mk(bit v, bit rd, bit wr,
    bit regwr, bit [4:0] wa, bit [31:0] res,
    bit [31:0] st);
    ins_t i;
    i.v = v; i.rd = rd; i.wr = wr; i.regwr = regwr;
    i.wa = wa; i.res = res; i.st = st;
    return i;
  endfunction

  ins_t nop;
  ins_t cur_i;
  bit   cur_stall, cur_flush;

  task automatic setin(ins_t i, bit stall, bit flush);
    cur_i = i; cur_stall = stall; cur_flush = flush;
    EX_VALID = i.v; EX_MEMRD = i.rd; EX_MEMWR = i.wr;
    EX_REGWR = i.regwr; EX_WA = i.wa;
    EX_RESULT = i.res; EX_STDATA = i.st;
    STALL = stall; FLUSH = flush;
  endtask

  // Instruction-level model: what retires at this edge
  task automatic tick();
    @(posedge CLK);
    if (!cur_stall) begin
      if (slot.v && slot.wr)
        mmem[slot.res[5:2]] = slot.st;
      else if (slot.v && slot.regwr)
        q.push_back('{slot.wa, slot.rd ?
                      mmem[slot.res[5:2]] : slot.res});
      slot = cur_flush ? nop : cur_i;
    end
    #1;
  endtask

  bit  e_req, e_fwd, e_ld;
  wb_t e_wb;

  always @(negedge CLK) begin
    if (!RST && run) begin
      e_req = slot.v && (slot.rd || slot.wr) && !STALL;
      chk("dreq", DREQ, e_req);
      if (e_req) begin
        chk("drw", DRW, slot.wr);
        chk("daddr", DADDR, slot.res[31:2]);
        chk("dwdata", DWDATA, slot.st);
      end else begin
        chk("daddr_idle", DADDR, 0);
        chk("dwdata_idle", DWDATA, 0);
      end
      e_fwd = slot.v && slot.regwr && !slot.rd && !slot.wr;
      chk("fwd_valid", FWD_M_VALID, e_fwd);
      if (e_fwd) begin
        chk("fwd_wa", FWD_M_WA, slot.wa);
        chk("fwd_data", FWD_M_DATA, slot.res);
      end
      e_ld = slot.v && slot.rd && !slot.wr;
      chk("ld_pending", LD_PENDING, e_ld);
      if (e_ld) chk("ld_wa", LD_WA, slot.wa);
      if (q.size() != 0) begin
        e_wb = q.pop_front();
        chk("wb_wen", WB_WEN, 1);
        if (WB_WEN) begin
          chk("wb_wa", WB_WA, e_wb.wa);
          chk("wb_di", WB_DI, e_wb.di);
        end
      end else begin
        chk("wb_idle", WB_WEN, 0);
      end
    end
  end

  int dreq_cnt;

  initial begin
    nop = mk(0, 0, 0, 0, 0, 0, 0);
    slot = nop;
    for (int i = 0; i < 16; i++) begin
      mmem[i] = 0; dmem[i] = 0;
    end
    mmem[4] = 32'hDEAD_BEEF;
    dmem[4] = 32'hDEAD_BEEF;
    RST = 1'b1;
    setin(mk(1, 1, 0, 1, 3, 32'h10, 32'h1), 0, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_dreq", DREQ, 0);
    chk("rst_wb_wen", WB_WEN, 0);
    chk("rst_daddr", DADDR, 0);
    chk("rst_dwdata", DWDATA, 0);
    chk("rst_ld_pend", LD_PENDING, 0);
    chk("rst_fwd", FWD_M_VALID, 0);
    chk("rst_fwd_data", FWD_M_DATA, 0);
    chk("rst_wb_di", WB_DI, 0);
    RST = 1'b0;
    run = 1'b1;

    // load word 4
    tick();
    setin(nop, 0, 0);
    @(negedge CLK);
    chk("ld_dreq", DREQ, 1);
    chk("ld_drw", DRW, 0);
    chk("ld_daddr", DADDR, 30'h4);
    chk("ld_pend", LD_PENDING, 1);
    chk("ld_wa3", LD_WA, 3);
    tick();
    @(negedge CLK);
    chk("ld_wb_wen", WB_WEN, 1);
    chk("ld_wb_wa", WB_WA, 3);
    chk("ld_wb_di", WB_DI, 32'hDEAD_BEEF);

    // store
    setin(mk(1, 0, 1, 0, 0, 32'h20, 32'h1234_5678), 0, 0);
    tick();
    setin(nop, 0, 0);
    @(negedge CLK);
    chk("st_dreq", DREQ, 1);
    chk("st_drw", DRW, 1);
    chk("st_daddr", DADDR, 30'h8);
    chk("st_dwdata", DWDATA, 32'h1234_5678);
    tick();
    @(negedge CLK);
    chk("st_wb_wen", WB_WEN, 0);

    // ALU op
    setin(mk(1, 0, 0, 1, 5, 32'h7, 32'h0), 0, 0);
    tick();
    setin(nop, 0, 0);
    @(negedge CLK);
    chk("alu_fwd_v", FWD_M_VALID, 1);
    chk("alu_fwd_d", FWD_M_DATA, 7);
    chk("alu_dreq", DREQ, 0);
    tick();
    @(negedge CLK);
    chk("alu_wb_di", WB_DI, 7);
    chk("alu_wb_wen", WB_WEN, 1);

    // load held by a two-cycle stall
    setin(mk(1, 1, 0, 1, 9, 32'h10, 32'h0), 0, 0);
    tick();
    dreq_cnt = 0;
    for (int c = 0; c < 2; c++) begin
      setin(nop, 1, 0);
      @(negedge CLK);
      chk("stall_dreq", DREQ, 0);
      chk("stall_wb_wen", WB_WEN, 0);
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      setin(nop, 0, 0);
      @(negedge CLK);
      if (DREQ) dreq_cnt++;
      tick();
    end
    chk("stall_once", dreq_cnt, 1);

    // flush
    setin(mk(1, 0, 0, 1, 6, 32'h55, 32'h0), 0, 1);
    tick();
    setin(nop, 0, 0);
    @(negedge CLK);
    chk("fl_fwd", FWD_M_VALID, 0);
    tick();
    @(negedge CLK);
    chk("fl_wb_wen", WB_WEN, 0);

    // rd and wr both set
    setin(mk(1, 1, 1, 1, 7, 32'h30, 32'hCAFE_0001), 0, 0);
    tick();
    setin(nop, 0, 0);
    @(negedge CLK);
    chk("ill_dreq", DREQ, 1);
    chk("ill_drw", DRW, 1);
    chk("ill_daddr", DADDR, 30'hC);
    tick();
    @(negedge CLK);
    chk("ill_wb_wen", WB_WEN, 0);

    // top of address space
    setin(mk(1, 0, 1, 0, 0, 32'hFFFF_FFFF,
             32'h0BAD_0001), 0, 0);
    tick();
    setin(nop, 0, 0);
    @(negedge CLK);
    chk("max_daddr", DADDR, 30'h3FFF_FFFF);
    tick();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      int k;
      bit s, f;
      ins_t r;
      k = $urandom_range(0, 3);
      s = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 7) == 0);
      case (k)
        0: r = nop;
        1: r = mk(1, 1, 0, 1, 5'($urandom_range(1, 31)),
                  32'($urandom_range(0, 63)), $urandom);
        2: r = mk(1, 0, 1, 0, 5'($urandom_range(1, 31)),
                  32'($urandom_range(0, 63)), $urandom);
        default:
           r = mk(1, 0, 0, ($urandom_range(0, 3) != 0),
                  5'($urandom_range(1, 31)), $urandom,
                  $urandom);
      endcase
      setin(r, s, f);
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      setin(nop, 0, 0);
      tick();
    end
    @(negedge CLK);
    chk("drain", q.size(), 0);

    // reset with a request on the port
    setin(mk(1, 1, 0, 1, 2, 32'h8, 32'h0), 0, 0);
    tick();
    setin(nop, 0, 0);
    @(negedge CLK);
    #2;
    chk("pre_rst_dreq", DREQ, 1);
    RST = 1'b1;
    #1;
    chk("async_dreq", DREQ, 0);
    chk("async_ld_pend", LD_PENDING, 0);
    chk("async_wb_wen", WB_WEN, 0);
    slot = nop;
    q.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
